// File: rtl/uart_frame_parser.sv
// Assembles SOF/CMD/LEN/payload/CHK frames from the UART byte strobe and holds a
// checksum-good frame for the host until acknowledged; bad frames raise one-cycle error pulses.
module uart_frame_parser #(
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 100000,
  parameter int ADDR_W      = $clog2(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic              rx_err,
  output logic              frame_valid,
  output logic [7:0]        frame_cmd,
  output logic [7:0]        frame_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              frame_ack,
  output logic              err_chk,
  output logic              err_len,
  output logic              err_framing,
  output logic              err_timeout,
  output logic              err_overrun
);

  localparam int          TW   = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  SOF  = 8'hA5;
  localparam logic [7:0]  MAXL = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    acc;
  logic [7:0]    idx;
  logic [TW-1:0] tcnt;
  logic [7:0]    pbuf [MAX_LEN];
  logic          active;
  logic          chk_nxt, len_nxt, framing_nxt, timeout_nxt, overrun_nxt;

  assign frame_valid = (state == S_HOLD);

  always_comb begin
    state_nxt   = state;
    chk_nxt     = 1'b0;
    len_nxt     = 1'b0;
    framing_nxt = 1'b0;
    timeout_nxt = 1'b0;
    overrun_nxt = 1'b0;
    active      = (state inside {S_CMD, S_LEN, S_PAYLOAD, S_CHK});
    case (state)
      S_IDLE: begin
        if (rx_done) begin
          if (rx_err)              framing_nxt = 1'b1;
          else if (rx_data == SOF) state_nxt   = S_CMD;
        end
      end
      S_HOLD: begin
        // Any byte here, framing-bad or not, is an overrun; the held frame is untouched.
        if (rx_done)   overrun_nxt = 1'b1;
        if (frame_ack) state_nxt   = S_IDLE;
      end
      default: begin
        if (rx_done) begin
          if (rx_err) begin
            framing_nxt = 1'b1;
            state_nxt   = S_IDLE;
          end else begin
            case (state)
              S_CMD: state_nxt = S_LEN;
              S_LEN: begin
                if (rx_data > MAXL) begin
                  len_nxt   = 1'b1;
                  state_nxt = S_IDLE;
                end else if (rx_data == 8'h00) begin
                  state_nxt = S_CHK;
                end else begin
                  state_nxt = S_PAYLOAD;
                end
              end
              S_PAYLOAD: if (idx == frame_len - 8'd1) state_nxt = S_CHK;
              S_CHK: begin
                if (rx_data == acc) begin
                  state_nxt = S_HOLD;
                end else begin
                  chk_nxt   = 1'b1;
                  state_nxt = S_IDLE;
                end
              end
              default: state_nxt = S_IDLE;
            endcase
          end
        end else if (tcnt == TLIM) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      acc         <= 8'h00;
      idx         <= 8'h00;
      tcnt        <= '0;
      frame_cmd   <= 8'h00;
      frame_len   <= 8'h00;
      rd_data     <= 8'h00;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_framing <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      err_chk     <= chk_nxt;
      err_len     <= len_nxt;
      err_framing <= framing_nxt;
      err_timeout <= timeout_nxt;
      err_overrun <= overrun_nxt;
      rd_data     <= (8'(rd_addr) < frame_len) ? pbuf[rd_addr] : 8'h00;

      // Inter-byte timer restarts on every byte and every state change.
      if (rx_done || !active || (state_nxt != state)) tcnt <= '0;
      else                                              tcnt <= tcnt + TW'(1);

      if (rx_done && !rx_err) begin
        case (state)
          S_IDLE: if (rx_data == SOF) acc <= 8'h00;
          S_CMD: begin
            frame_cmd <= rx_data;
            acc       <= rx_data;
          end
          S_LEN: begin
            if (rx_data <= MAXL) begin
              frame_len <= rx_data;
              acc       <= acc ^ rx_data;
              idx       <= 8'h00;
            end
          end
          S_PAYLOAD: begin
            acc <= acc ^ rx_data;
            idx <= idx + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && rx_done && !rx_err && (state == S_PAYLOAD))
      pbuf[idx[ADDR_W-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: scoreboard of expected frames plus
// per-scenario tasks checking error pulses, read port, timeout and reset.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TO      = 20;
  localparam int AW      = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_err = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          frame_ack = 1'b0;
  logic          frame_valid;
  logic [7:0]    frame_cmd, frame_len, rd_data;
  logic          err_chk, err_len, err_framing, err_timeout, err_overrun;

  int n_cmp = 0;
  int n_bad = 0;
  int c_chk = 0, c_len = 0, c_frm = 0, c_to = 0, c_ovr = 0;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] len;
  } frm_t;

  frm_t       exp_q[$];
  frm_t       mon_e;
  logic [7:0] seq[$];
  logic       fv_prev = 1'b0;

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .rx_done(rx_done), .rx_data(rx_data), .rx_err(rx_err),
    .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_len(frame_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_ack(frame_ack),
    .err_chk(err_chk), .err_len(err_len), .err_framing(err_framing),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard side: count pulses, check exclusivity, pop an expected frame on each frame_valid rise.
  always @(negedge clk) begin
    if (err_chk)     c_chk++;
    if (err_len)     c_len++;
    if (err_framing) c_frm++;
    if (err_timeout) c_to++;
    if (err_overrun) c_ovr++;
    if ({err_chk, err_len, err_framing, err_timeout, err_overrun} != 5'b0) begin
      n_cmp++;
      if ($countones({err_chk, err_len, err_framing, err_timeout, err_overrun}) != 1) begin
        n_bad++;
        $display("FAIL err_onehot: got %b, need exactly one bit",
                 {err_chk, err_len, err_framing, err_timeout, err_overrun});
      end
    end
    if (frame_valid === 1'b1 && fv_prev !== 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL frame_unexpected: cmd %h len %h, none expected", frame_cmd, frame_len);
      end else begin
        mon_e = exp_q.pop_front();
        if ({frame_cmd, frame_len} !== {mon_e.cmd, mon_e.len}) begin
          n_bad++;
          $display("FAIL frame_fields: got cmd %h len %h, want cmd %h len %h",
                   frame_cmd, frame_len, mon_e.cmd, mon_e.len);
        end
      end
    end
    fv_prev = frame_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    tick();
    rx_done = 1'b1;
    rx_data = b;
    rx_err  = e;
    tick();
    rx_done = 1'b0;
    rx_err  = 1'b0;
  endtask

  task automatic send_seq();
    foreach (seq[i]) send_byte(seq[i], 1'b0);
  endtask

  // Good frame with payload seed, seed+1, ...; expected result queued as it is sent.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] seed);
    logic [7:0] chk;
    chk = cmd ^ len;
    exp_q.push_back('{cmd: cmd, len: len});
    send_byte(8'hA5, 1'b0);
    send_byte(cmd, 1'b0);
    send_byte(len, 1'b0);
    for (int i = 0; i < int'(len); i++) begin
      send_byte(seed + 8'(i), 1'b0);
      chk = chk ^ (seed + 8'(i));
    end
    send_byte(chk, 1'b0);
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({frame_valid, frame_cmd, frame_len, rd_data, err_chk, err_len, err_framing,
         err_timeout, err_overrun} !== 30'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: valid %b cmd %h len %h rd %h, want all zero",
               frame_valid, frame_cmd, frame_len, rd_data);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    logic [7:0] pay [3] = '{8'h10, 8'h20, 8'h30};
    logic [7:0] want;
    exp_q.push_back('{cmd: 8'h01, len: 8'h03});
    seq = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h02};
    send_seq();
    tick();
    n_cmp++;
    if (exp_q.size() != 0 || frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL good_frame_seen: valid %b pending %0d, want valid 1 pending 0", frame_valid, exp_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      rd_addr = AW'(i);
      tick();
      want = (i < 3) ? pay[i] : 8'h00;
      n_cmp++;
      if (rd_data !== want) begin
        n_bad++;
        $display("FAIL good_rd_data[%0d]: got %h want %h", i, rd_data, want);
      end
    end
    do_ack();
    n_cmp++;
    if (frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL good_ack: frame_valid %b want 0", frame_valid);
    end
  endtask

  task automatic test_bad_chk();
    int c0 = c_chk;
    seq = '{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03};
    send_seq();
    tick(); tick();
    n_cmp++;
    if ((c_chk - c0) != 1 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_chk: pulses %0d valid %b, want 1 and 0", c_chk - c0, frame_valid);
    end
    exp_q.push_back('{cmd: 8'h7E, len: 8'h00});
    seq = '{8'hA5, 8'h7E, 8'h00, 8'h7E};
    send_seq();
    tick();
    n_cmp++;
    if (exp_q.size() != 0 || {frame_valid, frame_cmd, frame_len} !== {1'b1, 8'h7E, 8'h00}) begin
      n_bad++;
      $display("FAIL chk_recover: valid %b cmd %h len %h, want 1 7e 00", frame_valid, frame_cmd, frame_len);
    end
    do_ack();
  endtask

  task automatic test_len_garbage();
    int c0 = c_len;
    seq = '{8'hA5, 8'h02, 8'h11};
    send_seq();
    tick(); tick();
    n_cmp++;
    if ((c_len - c0) != 1 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL len_too_big: pulses %0d valid %b, want 1 and 0", c_len - c0, frame_valid);
    end
    exp_q.push_back('{cmd: 8'h02, len: 8'h01});
    seq = '{8'h55, 8'hA5, 8'h02, 8'h01, 8'hAA, 8'hA9};
    send_seq();
    rd_addr = '0;
    tick(); tick();
    n_cmp++;
    if (exp_q.size() != 0 || rd_data !== 8'hAA) begin
      n_bad++;
      $display("FAIL garbage_frame: pending %0d rd_data %h, want 0 and aa", exp_q.size(), rd_data);
    end
    do_ack();
  endtask

  task automatic test_timeout();
    int c0 = c_to;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (TO) tick();
    n_cmp++;
    if (c_to != c0) begin
      n_bad++;
      $display("FAIL timeout_early: pulses %0d want 0", c_to - c0);
    end
    tick();
    n_cmp++;
    if ((c_to - c0) != 1) begin
      n_bad++;
      $display("FAIL timeout_pulse: pulses %0d want 1", c_to - c0);
    end
    send_frame(8'h33, 8'h02, 8'h40);
    tick();
    n_cmp++;
    if (exp_q.size() != 0 || frame_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_recover: pending %0d valid %b, want 0 and 1", exp_q.size(), frame_valid);
    end
    do_ack();
    // LEN byte lands on the expiry edge itself.
    c0 = c_to;
    exp_q.push_back('{cmd: 8'h01, len: 8'h00});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (TO - 2) tick();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    tick();
    n_cmp++;
    if (c_to != c0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL timeout_edge_byte: pulses %0d pending %0d, want 0 and 0", c_to - c0, exp_q.size());
    end
    do_ack();
  endtask

  task automatic test_overrun_framing();
    int c0;
    int c1;
    send_frame(8'h5C, 8'h02, 8'h60);
    tick();
    c0 = c_ovr;
    c1 = c_frm;
    send_byte(8'h42, 1'b0);
    send_byte(8'h13, 1'b1);
    rd_addr = AW'(1);
    tick(); tick();
    n_cmp++;
    if ((c_ovr - c0) != 2 || c_frm != c1) begin
      n_bad++;
      $display("FAIL overrun_pulses: ovr %0d frm %0d, want 2 and 0", c_ovr - c0, c_frm - c1);
    end
    n_cmp++;
    if ({frame_valid, frame_cmd, frame_len, rd_data} !== {1'b1, 8'h5C, 8'h02, 8'h61}) begin
      n_bad++;
      $display("FAIL overrun_hold: valid %b cmd %h len %h rd %h, want 1 5c 02 61",
               frame_valid, frame_cmd, frame_len, rd_data);
    end
    rx_done = 1'b1;
    rx_data = 8'h42;
    frame_ack = 1'b1;
    tick();
    rx_done = 1'b0;
    frame_ack = 1'b0;
    tick();
    n_cmp++;
    if ((c_ovr - c0) != 3 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_with_ack: ovr %0d valid %b, want 3 and 0", c_ovr - c0, frame_valid);
    end
    seq = '{8'hA5, 8'h05, 8'h02, 8'h11};
    send_seq();
    send_byte(8'h22, 1'b1);
    tick(); tick();
    n_cmp++;
    if ((c_frm - c1) != 1 || frame_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL framing_payload: frm %0d valid %b, want 1 and 0", c_frm - c1, frame_valid);
    end
    // A corrupted SOF must not start a frame.
    send_byte(8'hA5, 1'b1);
    exp_q.push_back('{cmd: 8'h09, len: 8'h00});
    seq = '{8'hA5, 8'h09, 8'h00, 8'h09};
    send_seq();
    tick();
    n_cmp++;
    if ((c_frm - c1) != 2 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL framing_idle: frm %0d pending %0d, want 2 and 0", c_frm - c1, exp_q.size());
    end
    do_ack();
  endtask

  task automatic test_reset_mid();
    int e0 = c_chk + c_len + c_frm + c_to + c_ovr;
    seq = '{8'hA5, 8'h05, 8'h03, 8'h11};
    send_seq();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_cmp++;
    if ({frame_valid, frame_cmd, frame_len, rd_data, err_chk, err_len, err_framing,
         err_timeout, err_overrun} !== 30'b0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: valid %b cmd %h len %h rd %h, want all zero",
               frame_valid, frame_cmd, frame_len, rd_data);
    end
    tick(); tick();
    n_cmp++;
    if ((c_chk + c_len + c_frm + c_to + c_ovr) != e0) begin
      n_bad++;
      $display("FAIL reset_mid_pulses: got %0d new pulses, want 0", c_chk + c_len + c_frm + c_to + c_ovr - e0);
    end
    send_frame(8'h21, 8'h03, 8'h70);
    rd_addr = AW'(2);
    tick(); tick();
    n_cmp++;
    if (exp_q.size() != 0 || rd_data !== 8'h72) begin
      n_bad++;
      $display("FAIL reset_recover: pending %0d rd %h, want 0 and 72", exp_q.size(), rd_data);
    end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_garbage();
    test_timeout();
    test_overrun_framing();
    test_reset_mid();
    repeat (3) tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d frames never seen, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
